// File: rtl/nios2_oci_dct_pkg.sv
// nios2_oci_dct_pkg: shared widths and end-of-test state for the DCT packer
package nios2_oci_dct_pkg;
  localparam int DCT_CODE_W = 2;
  localparam int DCT_SLOTS = 15;
  localparam int DCT_BUF_W = DCT_CODE_W * DCT_SLOTS;
  localparam int DCT_CNT_W = 4;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} dct_state_t;
endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// nios2_oci_dct_outreg: valid/ready holding register for one packed DCT frame
module nios2_oci_dct_outreg
  import nios2_oci_dct_pkg::*;
#(
  parameter int BUF_W = DCT_BUF_W,
  parameter int CNT_W = DCT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buf,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count
);
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dct_buffer <= '0;
      dct_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      dct_buffer <= load_buf;
      dct_count <= load_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs trace codes into DCT frames; DCT_PACKER_STATS_EN adds frame/drop counters
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
#(
  parameter int CODE_W = DCT_CODE_W,
  parameter int SLOTS = DCT_SLOTS,
  localparam int BUF_W = CODE_W * SLOTS,
  localparam int CNT_W = DCT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  input  logic              flush,
  input  logic              test_ending,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  output logic              test_has_ended
`ifdef DCT_PACKER_STATS_EN
  ,
  output logic [15:0]       frames_sent,
  output logic [15:0]       codes_dropped
`endif
);
  logic [BUF_W-1:0] acc_buf;
  logic [CNT_W-1:0] acc_cnt;
  logic pend;
  dct_state_t state;
  logic full, empty, out_free, flush_req, handoff, take, accept, drop, drained;
  assign full = acc_cnt == CNT_W'(SLOTS);
  assign empty = acc_cnt == '0;
  assign out_free = !out_valid || out_ready;
  // anything past RUN keeps flushing so the drain completes without further requests
  assign flush_req = flush || test_ending || pend || state != RUN;
  assign handoff = out_free && !empty && (full || flush_req);
  assign take = code_valid && state == RUN && !test_ending;
  assign accept = take && (!full || handoff);
  assign drop = take && full && !handoff;
  assign drained = state == DRAIN && empty && !out_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_buf <= '0;
      acc_cnt <= '0;
      pend <= 1'b0;
      state <= RUN;
      overflow <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      acc_buf <= handoff ? (accept ? BUF_W'(code) : '0)
               : accept ? {acc_buf[BUF_W-CODE_W-1:0], code} : acc_buf;
      acc_cnt <= handoff ? CNT_W'(accept) : acc_cnt + CNT_W'(accept);
      pend <= !handoff && (pend || (flush && !empty));
      overflow <= overflow || drop;
      state <= (state == RUN && test_ending) ? DRAIN : drained ? DONE : state;
      test_has_ended <= test_has_ended || drained;
    end
  end
  nios2_oci_dct_outreg #(.BUF_W(BUF_W), .CNT_W(CNT_W)) u_outreg (
    .clk(clk),
    .reset(reset),
    .load(handoff),
    .load_buf(acc_buf),
    .load_cnt(acc_cnt),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .dct_buffer(dct_buffer),
    .dct_count(dct_count)
  );
`ifdef DCT_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_sent <= '0;
      codes_dropped <= '0;
    end else begin
      frames_sent <= frames_sent + 16'((out_valid && out_ready && frames_sent != 16'hFFFF));
      codes_dropped <= codes_dropped + 16'((drop && codes_dropped != 16'hFFFF));
    end
  end
`endif
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// tb_nios2_oci_dct_packer: directed and random stimulus checked against a queue-based packing model
module tb_nios2_oci_dct_packer;
  logic clk = 0, reset = 1, code_valid = 0, flush = 0, test_ending = 0, out_ready = 0;
  logic [1:0] code = 0;
  logic out_valid, overflow, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0] dct_count;
`ifdef DCT_PACKER_STATS_EN
  logic [15:0] frames_sent, codes_dropped;
`endif
  always #5 clk = ~clk;
  nios2_oci_dct_packer dut (
    .clk(clk),
    .reset(reset),
    .code_valid(code_valid),
    .code(code),
    .flush(flush),
    .test_ending(test_ending),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dct_buffer(dct_buffer),
    .dct_count(dct_count),
    .overflow(overflow),
    .test_has_ended(test_has_ended)
`ifdef DCT_PACKER_STATS_EN
    ,
    .frames_sent(frames_sent),
    .codes_dropped(codes_dropped)
`endif
  );
  int passed = 0, total = 0;
  bit go = 0;
  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // model: the accumulator is just a queue of codes, a frame is its base-4 value
  int mq[$];
  bit m_valid = 0, m_ovf = 0, m_end = 0, m_pend = 0;
  logic [29:0] m_buf = 0;
  int m_cnt = 0, m_state = 0, m_frames = 0, m_drops = 0;
  function automatic logic [29:0] pack();
    logic [29:0] r = 0;
    foreach (mq[i]) r = r * 4 + 30'(mq[i]);
    return r;
  endfunction
  always @(posedge clk) begin : model
    int n;
    bit ov, ho, take;
    n = mq.size();
    ov = m_valid;
    if (reset) begin
      mq.delete();
      m_valid = 0; m_buf = 0; m_cnt = 0; m_ovf = 0; m_end = 0; m_pend = 0;
      m_state = 0; m_frames = 0; m_drops = 0;
    end else begin
      ho = (!ov || out_ready) && n > 0 && (n == 15 || flush || test_ending || m_pend || m_state != 0);
      take = code_valid && m_state == 0 && !test_ending;
      if (ov && out_ready && m_frames < 65535) m_frames++;
      if (m_state == 0 && test_ending) m_state = 1;
      else if (m_state == 1 && n == 0 && !ov) begin
        m_state = 2;
        m_end = 1;
      end
      if (ho) begin
        m_buf = pack();
        m_cnt = n;
        m_valid = 1;
        mq.delete();
        m_pend = 0;
      end else begin
        if (ov && out_ready) m_valid = 0;
        if (flush && n > 0) m_pend = 1;
      end
      if (take) begin
        if (mq.size() < 15) mq.push_back(int'(code));
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (go) begin
      chk("out_valid", out_valid, m_valid);
      chk("overflow", overflow, m_ovf);
      chk("test_has_ended", test_has_ended, m_end);
      if (m_valid) begin
        chk("dct_count", dct_count, m_cnt);
        chk("dct_buffer", dct_buffer, m_buf);
      end
`ifdef DCT_PACKER_STATS_EN
      chk("frames_sent", frames_sent, m_frames);
      chk("codes_dropped", codes_dropped, m_drops);
`endif
    end
  end
  task automatic cyc(bit cv, logic [1:0] c, bit fl, bit te, bit rdy);
    code_valid = cv; code = c; flush = fl; test_ending = te; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    cyc(0, 0, 0, 0, 0);
    reset = 0;
  endtask
  initial begin
    reset = 1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    reset = 0;
    go = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_buffer", dct_buffer, 0);
    chk("rst_count", dct_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ended", test_has_ended, 0);
    // full frame of 0,1,2,3,...
    for (int i = 0; i < 15; i++) cyc(1, 2'(i % 4), 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("full_valid", out_valid, 1);
    chk("full_count", dct_count, 15);
    chk("full_buffer", dct_buffer, 30'h06C6C6C6);
    chk("model_full_pack", m_buf, 30'h06C6C6C6);
    cyc(0, 0, 0, 0, 1);
    // partial frame via flush, then flush on empty
    cyc(1, 3, 0, 0, 1);
    cyc(1, 2, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("flush_count", dct_count, 3);
    chk("flush_buffer", dct_buffer, 30'h39);
    chk("model_flush_pack", m_buf, 30'h39);
    cyc(0, 0, 1, 0, 1);
    chk("empty_flush_valid", out_valid, 0);
    // back-pressure overflow
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1, 2'(i % 4), 0, 0, 0);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_count", dct_count, 15);
    chk("ovf_buffer", dct_buffer, 30'h06C6C6C6);
    chk("ovf_flag", overflow, 1);
    chk("ovf_model_acc", mq.size(), 15);
`ifdef DCT_PACKER_STATS_EN
    chk("ovf_dropped", codes_dropped, 2);
`endif
    repeat (3) cyc(0, 0, 0, 0, 1);
    // 16th code lands in the fresh accumulator
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 2'(i % 4), 0, 0, 1);
    chk("h16_count", dct_count, 15);
    chk("h16_buffer", dct_buffer, 30'h06C6C6C6);
    chk("h16_model_acc", mq.size(), 1);
    cyc(0, 0, 1, 0, 1);
    chk("h16_next_count", dct_count, 1);
    chk("h16_next_buffer", dct_buffer, 3);
    // end of test with codes still arriving
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 2'(i % 4), 0, 0, 1);
    cyc(1, 2, 0, 1, 1);
    chk("te_count", dct_count, 5);
    chk("te_buffer", dct_buffer, 30'h6C);
    for (int i = 0; i < 20 && !test_has_ended; i++) cyc(1, 2'($urandom), 0, 0, 1);
    chk("te_ended", test_has_ended, 1);
    chk("te_overflow", overflow, 0);
    chk("te_valid", out_valid, 0);
    // reset with a held frame and a partial accumulator
    do_reset();
    for (int i = 0; i < 22; i++) cyc(1, 2'(i % 4), 0, 0, 0);
    chk("mid_held", out_valid, 1);
    reset = 1;
    cyc(1, 3, 0, 0, 1);
    reset = 0;
    chk("mid_valid", out_valid, 0);
    chk("mid_buffer", dct_buffer, 0);
    chk("mid_count", dct_count, 0);
    chk("mid_ended", test_has_ended, 0);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 2, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("post_rst_count", dct_count, 2);
    chk("post_rst_buffer", dct_buffer, 6);
    // random traffic with bursty back-pressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit stall = (i / 150) % 3 == 2;
      cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 9) == 0, 0,
          stall ? $urandom_range(0, 7) == 0 : $urandom_range(0, 2) != 0);
    end
    cyc(1, 1, 0, 1, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 30 && !test_has_ended; i++) cyc($urandom_range(0, 1) == 1, 2'($urandom), 0, 0, 1);
    chk("rand_ended", test_has_ended, 1);
    go = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
